// File: rtl/vending_pkg.sv
// Shared constants, state encoding and credit/state mapping for the Rs.20 vending controller.
package vending_pkg;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_15 = 2'b10;
  localparam logic [1:0] COIN_20 = 2'b11;

  localparam logic [5:0] PRICE = 6'd20;

  typedef enum logic [1:0] {S0, S5, S10, S15} state_t;

  function automatic state_t credit_to_state(input logic [5:0] credit);
    state_t s;
    case (credit)
      6'd0:    s = S0;
      6'd5:    s = S5;
      6'd10:   s = S10;
      6'd15:   s = S15;
      default: s = S0;
    endcase
    return s;
  endfunction

  function automatic logic [5:0] state_to_credit(input state_t s);
    logic [5:0] c;
    case (s)
      S0:      c = 6'd0;
      S5:      c = 6'd5;
      S10:     c = 6'd10;
      S15:     c = 6'd15;
      default: c = 6'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vending_fsm_coin_decoder.sv
// Combinational coin-code to rupee-value decoder.
module coin_decoder
  import vending_pkg::*;
(
  input  logic [1:0] x_i,
  output logic [5:0] value_o
);

  always_comb begin
    case (x_i)
      COIN_5:  value_o = 6'd5;
      COIN_10: value_o = 6'd10;
      COIN_15: value_o = 6'd15;
      COIN_20: value_o = 6'd20;
      default: value_o = 6'd0;
    endcase
  end

endmodule

// File: rtl/vending_fsm.sv
// Single-product (Rs.20) vending FSM: one coin per clock, registered item count and refund pulse.
// Define REFUND_EN to return overpayment as a refund pulse; otherwise the excess is carried as credit.
module vending_fsm
  import vending_pkg::*;
(
  input  logic       clk,
  output logic [3:0] item,
  input  logic [1:0] x,
  input  logic       rst,
  output logic       refund
);

  logic [5:0] coin_value_s;
  logic [5:0] sum_d;
  state_t     state_q, state_d;
  logic [3:0] item_q, item_d;
  logic       refund_q, refund_d;

  coin_decoder u_coin_decoder (
    .x_i     (x),
    .value_o (coin_value_s)
  );

  always_comb begin
    sum_d    = state_to_credit(state_q) + coin_value_s;
    state_d  = state_q;
    item_d   = item_q;
    refund_d = 1'b0;
    if (sum_d < PRICE) begin
      state_d = credit_to_state(sum_d);
    end else begin
      item_d = item_q + 4'd1;
      if (sum_d == PRICE) begin
        state_d = S0;
      end else begin
`ifdef REFUND_EN
        state_d  = S0;
        refund_d = 1'b1;
`else
        state_d  = credit_to_state(sum_d - PRICE);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S0;
      item_q   <= 4'd0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      refund_q <= refund_d;
    end
  end

  assign item   = item_q;
  assign refund = refund_q;

endmodule

// File: tb/tb_vending_fsm.sv
// Scoreboard bench for vending_fsm: directed coin vectors with hand-computed item/refund values.
module tb_vending_fsm;

  logic       clk;
  logic [3:0] item;
  logic [1:0] x;
  logic       rst;
  logic       refund;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [3:0] item;
    logic       refund;
  } exp_t;

  exp_t exp_q[$];

  vending_fsm dut (
    .clk    (clk),
    .item   (item),
    .x      (x),
    .rst    (rst),
    .refund (refund)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values: (i_r, r_r) when REFUND_EN is defined, (i_c, r_c) when excess is carried.
  task automatic vec(input logic [1:0] xv, input logic rv,
                     input logic [3:0] i_r, input logic r_r,
                     input logic [3:0] i_c, input logic r_c);
    exp_t e;
    @(negedge clk);
    x   = xv;
    rst = rv;
`ifdef REFUND_EN
    e.item = i_r; e.refund = r_r;
`else
    e.item = i_c; e.refund = r_c;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compare just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (item !== e.item || refund !== e.refund) begin
        miscompares = miscompares + 1;
        $display("FAIL vec%0d: item=%0d refund=%0b, required item=%0d refund=%0b",
                 vectors, item, refund, e.item, e.refund);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    x   = 2'b11;
    rst = 1'b1;
    // Reset, coin ignored
    vec(2'b11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    // Exact pay with four Rs.5 coins
    vec(2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    // Overpay 5+10+15 = 30, then Rs.10
    vec(2'b00, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    vec(2'b01, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    vec(2'b10, 1'b0, 4'd2, 1'b1, 4'd2, 1'b0);
    vec(2'b01, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0);
    // Reset, then 17 Rs.20 coins: 1..15, 0, 1
    vec(2'b11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] n;
      n = 4'(i);
      vec(2'b11, 1'b0, n, 1'b0, n, 1'b0);
    end
    // From S0 with item=1: 10, 20, 20, 5
    vec(2'b01, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    vec(2'b11, 1'b0, 4'd2, 1'b1, 4'd2, 1'b0);
    vec(2'b11, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0);
    vec(2'b00, 1'b0, 4'd3, 1'b0, 4'd3, 1'b0);
    // Reset mid-accumulation discards credit
    vec(2'b11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b01, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    vec(2'b10, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    // 15 then 15+15 = 30, then Rs.10
    vec(2'b10, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
    vec(2'b10, 1'b0, 4'd2, 1'b1, 4'd2, 1'b0);
    vec(2'b01, 1'b0, 4'd2, 1'b0, 4'd3, 1'b0);
    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vending_fsm.md
# vending_fsm

Coin-accepting vending controller for a single Rs.20 product. Samples one coin per clock from a 2-bit coin code and accumulates credit in a four-state machine. When credit reaches the price it vends one item and either refunds or carries the excess. Standalone leaf block driven by the coin-acceptor front end; its outputs feed the dispenser and the change hopper.

## Interface
- No parameters. The price (Rs.20) and coin values are fixed constants in the package.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  2  coin code, sampled every rising edge: 00=Rs.5, 01=Rs.10, 10=Rs.15, 11=Rs.20.
- item  output  4  count of items vended since reset, modulo 16; registered.
- refund  output  1  one-cycle registered pulse: excess credit returned.
- Port order: clk, item, x, rst, refund.

## Operation
- There is no coin-valid strobe. Every clock edge without reset inserts exactly one coin, including code 00 (Rs.5).
- Credit states: S0 (0), S5, S10, S15. Credit never rests at Rs.20 or above.
- Each edge computes sum = credit + coin value. The sum is 6 bits wide; its maximum is 35.
- sum < 20:
  - next state is the state for sum.
  - item holds; refund=0.
- sum == 20:
  - item increments (wraps 15→0).
  - next state is S0; refund=0.
- sum > 20:
  - item increments (wraps 15→0).
  - Next state and refund depend on the configuration; see Configuration.
- Only one item is vended per edge.
- rst=1 has priority over everything else:
  - state goes to S0, item to 0, refund to 0.
  - The coin sampled in that cycle is discarded.

## Timing
- Coin sampled at edge N. The item increment and refund pulse are visible after edge N, for exactly the cycle N→N+1.
- refund returns to 0 on the next edge unless that cycle also overpays.
- Back-to-back vends are supported:
  - item increments on consecutive edges.
  - refund can stay high on consecutive overpaying edges.
- Reset values: item=0, refund=0, state S0.
- Reset applied mid-accumulation discards the credit with no refund pulse.
- Deasserting rst: the first coin is sampled on the first edge where rst=0.

## Configuration
- Macro REFUND_EN defined:
  - sum > 20 asserts refund for one cycle.
  - Next state is S0; the excess is returned, not carried.
- Macro REFUND_EN undefined:
  - refund is tied to 0.
  - Excess (sum−20, at most 15) is carried as credit: next state is the state for sum−20.

## Structure
- Package vending_pkg holds:
  - coin code constants COIN_5, COIN_10, COIN_15, COIN_20.
  - PRICE = 20.
  - state enum state_t {S0, S5, S10, S15}.
  - credit-to-state mapping function.
- Sub-module coin_decoder: combinational, x[1:0] → coin value (6-bit).
- Top: state register, sum/compare logic, item counter, refund register.

## Test plan
- Reset: rst=1 for one edge with any x → item=0, refund=0, state S0; the coin in that cycle is ignored.
- Exact pay: from S0, coins 00,00,00,00 → states S5, S10, S15; the 4th edge gives item=1, refund=0, state S0.
- Overpay, REFUND_EN defined: from S0, coins 00,01,10 (5+10+15=30) → 3rd edge gives item=1, refund=1 for one cycle, state S0.
- Overpay, REFUND_EN undefined: same 00,01,10 → item=1, refund=0, state S10 (carry 10); next coin 01 → item=2, state S0.
- Continuous Rs.20 coins (11) for 17 edges → item counts 1..15 then wraps 0, 1; refund stays 0.
- Reset mid-operation: from S0, coins 00,01 (state S15), then rst=1 with x=11 → state S0, item unchanged-to-0, no refund; after release, coin 00 → state S5.
